sklansky_subtractor: RTL and testbench
======================================

# sklansky_subtractor

Pipelined two's-complement subtractor computing `diff = a - b` on a Sklansky parallel-prefix borrow network. Operands enter through a valid/ready handshake, pass through one register stage per prefix level, and leave through a registered valid/ready output. It is the subtract-side counterpart to the combinational prefix adder, for datapaths that need `a - b` with a borrow out at full clock rate.

## Interface
- `WIDTH`, default 32: operand and result width, power of two, minimum 4.
- `NUM_STEPS`, default `$clog2(WIDTH)`: number of prefix levels. This is a derived localparam and is not overridable.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands `a` and `b` are valid this cycle.
- `in_ready`  out  1: the block accepts operands this cycle.
- `a`  in  WIDTH: minuend.
- `b`  in  WIDTH: subtrahend.
- `out_valid`  out  1: the result is valid.
- `out_ready`  in  1: the consumer accepts the result.
- `diff`  out  WIDTH: `a - b` mod 2^WIDTH.
- `borrow`  out  1: high when unsigned `a < b`.
- `zero`, `neg`, `ovf`  out  1 each: result flags (see Configuration).

## Operation
- Subtraction is computed as `a + ~b + 1`, with `b` inverted at the input.
  - The carry-in of 1 is folded into bit 0: `g0 = a0 | ~b0`.
  - Elsewhere `p_i = a_i ^ ~b_i` and `g_i = a_i & ~b_i`.
- Stage 0 registers `p`, `g`, the raw `p` (needed for the sum) and the operand MSBs.
- Stage k, for k = 1..NUM_STEPS, applies Sklansky level k to the stage k-1 register:
  - Positions with `(i mod 2^k) >= 2^(k-1)` combine with position `i - (i mod 2^(k-1)) - 1`.
  - If that position is below 2^k, the combine is gray (generate only); otherwise it is black (propagate and generate).
  - All other positions pass through unchanged.
- The output stage registers:
  - `diff_i = rawp_i ^ G_{i-1}`, with `G_{-1} = 1`.
  - `borrow = ~G_{WIDTH-1}`.
- A per-stage valid bit travels with the data.
- The pipe advances as a whole when `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - An input is captured only when `in_valid && adv`.
  - Bubbles are not compressed.

## Timing
- Latency is NUM_STEPS+2 cycles from the accepting edge to `out_valid`: 7 for WIDTH=32, 5 for WIDTH=8.
- Throughput is one result per cycle while `out_ready` stays high.
- Stall: when `out_valid && !out_ready`, every stage holds and `in_ready` is low.
  - `diff`, `borrow` and the flags stay stable until the result is accepted.
- Simultaneous accept at the output and capture at the input in the same cycle is legal and loses no data.
- Reset, asserted at any time including mid-operation:
  - All valid bits clear immediately and in-flight operands are discarded.
  - `out_valid = 0`, `diff = 0`, `borrow = 0`, `zero = neg = ovf = 0`.
  - `in_ready = 1` once reset is released.
- Result order is always input order.

## Configuration
- Macro `SKL_SUB_FLAGS_EN`.
- Defined:
  - `zero = (diff == 0)`.
  - `neg = diff[WIDTH-1]`.
  - `ovf = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1])`, i.e. signed overflow.
  - The flags are registered with `diff`, and the operand MSBs are carried through the pipeline.
- Undefined: `zero`, `neg` and `ovf` are tied to 0, and no MSB or flag registers exist.
- `diff`, `borrow` and the timing are identical either way.

## Structure
- Package `skl_pkg` holds:
  - The `pg_t` packed struct with `p` and `g` fields, parameterised by width through a typedef inside a parameterised class or by fixed maximum width.
  - Functions `black(pg_hi, pg_lo)` and `gray(pg_hi, g_lo)`.
- One sub-module, `skl_prefix_stage`. Parameters are `WIDTH` and `LEVEL`. It contains:
  - The level's combinational gray/black network.
  - Its pipeline register with the valid bit, enable `adv`, and async reset.
- The top level contains stage 0, a generate loop of NUM_STEPS `skl_prefix_stage` instances, the output stage and the handshake logic.

## Test plan
All cases use WIDTH=8.
- Basic subtraction: `a=5, b=3` → 5 cycles later `diff=0x02`, `borrow=0`, `zero=0`, `neg=0`, `ovf=0`.
- Borrow and negative result: `a=3, b=5` → `diff=0xFE`, `borrow=1`, `neg=1`, `ovf=0`.
- Signed overflow and zero:
  - `a=0x80, b=0x01` → `diff=0x7F`, `borrow=0`, `ovf=1`.
  - `a=0x2A, b=0x2A` → `diff=0`, `zero=1`.
- Backpressure: stream the 4 operand pairs (9,1), (1,9), (0xFF,0xFF), (0,1) with `out_ready` low for 3 cycles after the first `out_valid`.
  - `in_ready` goes low and the output holds 0x08 stable.
  - Results emerge in order: 0x08, 0xF8, 0x00, 0xFF.
  - No loss and no duplication.
- Reset mid-flight: accept 3 operands, then assert `reset` for 1 cycle.
  - `out_valid` goes low immediately and no stale result ever appears.
  - The next input after reset yields its result exactly 5 cycles later.
- Flags compiled out: rebuild without `SKL_SUB_FLAGS_EN` and repeat the signed-overflow case.
  - `diff` and `borrow` are unchanged.
  - `zero`, `neg` and `ovf` are constant 0.

Source files
------------

// File: rtl/skl_pkg.sv
// skl_pkg: shared types and prefix operators for the Sklansky subtractor.
//   pg_t           : one prefix-tree node (propagate, generate)
//   black()        : full prefix combine, produces group P and G
//   gray()         : generate-only combine, used once the low side is complete
//   skl_src_pos()  : position a node combines with at a given prefix level
// Optional feature macro used by the subtractor files: SKL_SUB_FLAGS_EN.
package skl_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Group (hi:lo) = hi combined with lo.
    function automatic pg_t black(pg_t pg_hi, pg_t pg_lo);
        pg_t r;
        r.p = pg_hi.p & pg_lo.p;
        r.g = pg_hi.g | (pg_hi.p & pg_lo.g);
        return r;
    endfunction

    // The low side already spans down to bit 0, so its group propagate is
    // never needed again; only the generate is folded in.
    function automatic pg_t gray(pg_t pg_hi, logic g_lo);
        pg_t r;
        r.p = pg_hi.p;
        r.g = pg_hi.g | (pg_hi.p & g_lo);
        return r;
    endfunction

    // Sklansky level k: node i reaches to the top of the lower half-block.
    function automatic int skl_src_pos(int i, int level);
        return i - (i % (1 << (level - 1))) - 1;
    endfunction

endpackage

// File: rtl/skl_prefix_stage.sv
// skl_prefix_stage: one Sklansky prefix level plus its pipeline register.
//   clk, reset       : clock, async active-high reset
//   adv              : pipeline advance enable (whole pipe moves together)
//   vld_in/vld_out   : stage valid bit
//   pg_in/pg_out     : per-bit prefix nodes, before/after this level
//   rawp_in/rawp_out : raw a ^ ~b, carried for the final sum
//   msb_in/msb_out   : {a_msb, b_msb}, only with SKL_SUB_FLAGS_EN
module skl_prefix_stage
    import skl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    input  logic                  vld_in,
    input  pg_t  [WIDTH-1:0]      pg_in,
    input  logic [WIDTH-1:0]      rawp_in,
`ifdef SKL_SUB_FLAGS_EN
    input  logic [1:0]            msb_in,
    output logic [1:0]            msb_out,
`endif
    output logic                  vld_out,
    output pg_t  [WIDTH-1:0]      pg_out,
    output logic [WIDTH-1:0]      rawp_out
);

    localparam int BLK  = 1 << LEVEL;
    localparam int HALF = 1 << (LEVEL - 1);

    pg_t [WIDTH-1:0] pg_nxt;

    // Upper half of every 2^LEVEL block combines with the top of the lower
    // half. In the first block that source is already complete to bit 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int J = skl_src_pos(i, LEVEL);
        if ((i % BLK) >= HALF) begin : g_comb
            if (J < BLK) begin : g_gray
                assign pg_nxt[i] = gray(pg_in[i], pg_in[J].g);
            end else begin : g_black
                assign pg_nxt[i] = black(pg_in[i], pg_in[J]);
            end
        end else begin : g_pass
            assign pg_nxt[i] = pg_in[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_out  <= 1'b0;
            pg_out   <= '0;
            rawp_out <= '0;
        end else if (adv) begin
            vld_out  <= vld_in;
            pg_out   <= pg_nxt;
            rawp_out <= rawp_in;
        end
    end

`ifdef SKL_SUB_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    msb_out <= '0;
        else if (adv) msb_out <= msb_in;
    end
`endif

endmodule

// File: rtl/sklansky_subtractor.sv
// sklansky_subtractor: pipelined diff = a - b on a Sklansky borrow network.
//   clk, reset           : clock, async active-high reset
//   in_valid/in_ready    : operand handshake (a minuend, b subtrahend)
//   out_valid/out_ready  : result handshake
//   diff, borrow         : a - b mod 2^WIDTH, unsigned a < b
//   zero, neg, ovf       : result flags, live only with SKL_SUB_FLAGS_EN,
//                          otherwise tied to 0
// Latency NUM_STEPS+2 register stages: input, NUM_STEPS prefix levels, output.
module sklansky_subtractor
    import skl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NUM_STEPS = $clog2(WIDTH);

    logic adv;

    // Stall only when a result is waiting and not taken; no bubble squeeze.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 0: a + ~b + 1 setup ----------------
    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] rawp_d;
    pg_t  [WIDTH-1:0] pg0_d;

    always_comb begin
        bn     = ~b;
        rawp_d = a ^ bn;
        pg0_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pg0_d[i].p = rawp_d[i];
            pg0_d[i].g = a[i] & bn[i];
        end
        // Carry-in of 1 folded into bit 0.
        pg0_d[0].g = a[0] | bn[0];
    end

    logic             s0_vld;
    pg_t  [WIDTH-1:0] s0_pg;
    logic [WIDTH-1:0] s0_rawp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_vld  <= 1'b0;
            s0_pg   <= '0;
            s0_rawp <= '0;
        end else if (adv) begin
            s0_vld  <= in_valid;
            s0_pg   <= pg0_d;
            s0_rawp <= rawp_d;
        end
    end

    // ---------------- prefix levels ----------------
    logic [NUM_STEPS:0] vld_pipe;
    pg_t  [WIDTH-1:0]   pg_s   [0:NUM_STEPS];
    logic [WIDTH-1:0]   rawp_s [0:NUM_STEPS];

    assign vld_pipe[0] = s0_vld;
    assign pg_s[0]     = s0_pg;
    assign rawp_s[0]   = s0_rawp;

`ifdef SKL_SUB_FLAGS_EN
    logic [1:0] s0_msb;
    logic [1:0] msb_s [0:NUM_STEPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    s0_msb <= '0;
        else if (adv) s0_msb <= {a[WIDTH-1], b[WIDTH-1]};
    end

    assign msb_s[0] = s0_msb;
`endif

    for (genvar k = 1; k <= NUM_STEPS; k++) begin : g_lvl
        skl_prefix_stage #(
            .WIDTH (WIDTH),
            .LEVEL (k)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .adv      (adv),
            .vld_in   (vld_pipe[k-1]),
            .pg_in    (pg_s[k-1]),
            .rawp_in  (rawp_s[k-1]),
`ifdef SKL_SUB_FLAGS_EN
            .msb_in   (msb_s[k-1]),
            .msb_out  (msb_s[k]),
`endif
            .vld_out  (vld_pipe[k]),
            .pg_out   (pg_s[k]),
            .rawp_out (rawp_s[k])
        );
    end

    // ---------------- output stage ----------------
    logic [WIDTH-1:0] gfin;
    logic [WIDTH-1:0] pfin_unused;
    logic             unused_p;
    logic [WIDTH-1:0] diff_d;

    always_comb begin
        gfin        = '0;
        pfin_unused = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gfin[i]        = pg_s[NUM_STEPS][i].g;
            pfin_unused[i] = pg_s[NUM_STEPS][i].p;
        end
    end

    // Group propagates are dead after the last level.
    assign unused_p = ^pfin_unused;

    // Carry into bit i is G[i-1]; carry into bit 0 is the folded-in 1.
    assign diff_d = rawp_s[NUM_STEPS] ^ {gfin[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_pipe[NUM_STEPS];
            diff      <= diff_d;
            borrow    <= ~gfin[WIDTH-1];
        end
    end

`ifdef SKL_SUB_FLAGS_EN
    logic am, bm;
    assign {am, bm} = msb_s[NUM_STEPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv) begin
            zero <= (diff_d == '0);
            neg  <= diff_d[WIDTH-1];
            // Signs differ and result sign disagrees with the minuend.
            ovf  <= (am ^ bm) & (am ^ diff_d[WIDTH-1]);
        end
    end
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_sklansky_subtractor.sv
// Bench for sklansky_subtractor at WIDTH=8: directed cases, backpressure,
// mid-flight reset, then a randomized stream against an arithmetic model.
// Flag expectations follow SKL_SUB_FLAGS_EN (zero when undefined).
module tb_sklansky_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow, zero, neg, ovf;

    int nvec = 0;
    int nerr = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  got[$];

    sklansky_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // {diff, borrow, zero, neg, ovf} from plain arithmetic.
    function automatic logic [11:0] model(logic [7:0] xa, logic [7:0] xb);
        logic [7:0] d;
        logic br, z, n, o;
        int sd;
        d  = xa - xb;
        br = (xa < xb);
        sd = int'($signed(xa)) - int'($signed(xb));
`ifdef SKL_SUB_FLAGS_EN
        z = (d == 8'h00);
        n = d[7];
        o = (sd > 127) || (sd < -128);
`else
        z = 1'b0;
        n = 1'b0;
        o = 1'b0;
`endif
        return {d, br, z, n, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: push on accepted input, compare front every valid cycle
    // (so a stalled output must stay equal to it), pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(diff), 32'hDEAD);
                end else begin
                    chk("stream", 32'({diff, borrow, zero, neg, ovf}), 32'(exp_q[0]));
                    if (out_ready) begin
                        got.push_back(diff);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    int lat;

    task automatic send_one(input logic [7:0] xa, input logic [7:0] xb,
                            input logic [7:0] xd, input string tag);
        @(posedge clk); #1;
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_diff"}, 32'(diff), 32'(xd));
        chk({tag, "_res"}, 32'({diff, borrow, zero, neg, ovf}), 32'(model(xa, xb)));
    endtask

    logic [7:0] bp_a [4] = '{8'h09, 8'h01, 8'hFF, 8'h00};
    logic [7:0] bp_b [4] = '{8'h01, 8'h09, 8'hFF, 8'h01};
    logic [7:0] bp_d [4] = '{8'h08, 8'hF8, 8'h00, 8'hFF};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({borrow, zero, neg, ovf}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed single operations.
        send_one(8'h05, 8'h03, 8'h02, "basic");
        chk("basic_borrow", 32'(borrow), 32'd0);
        send_one(8'h03, 8'h05, 8'hFE, "neg");
        chk("neg_borrow", 32'(borrow), 32'd1);
        send_one(8'h80, 8'h01, 8'h7F, "ovf");
        chk("ovf_borrow", 32'(borrow), 32'd0);
`ifdef SKL_SUB_FLAGS_EN
        chk("ovf_flag", 32'(ovf), 32'd1);
`else
        chk("ovf_flag_off", 32'({zero, neg, ovf}), 32'd0);
`endif
        send_one(8'h2A, 8'h2A, 8'h00, "zero");
`ifdef SKL_SUB_FLAGS_EN
        chk("zero_flag", 32'(zero), 32'd1);
`endif

        // Backpressure: stream 4, stall 3 cycles on first result.
        @(posedge clk); #1;
        got.delete();
        for (int k = 0; k < 4; k++) begin
            a = bp_a[k]; b = bp_b[k]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_first_seen", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(diff), 32'h08);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk("bp_order", 32'(got[k]), 32'(bp_d[k]));
        end

        // Reset mid-flight.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            a = 8'(8'h10 + k); b = 8'h01; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_valid_low", 32'(out_valid), 32'd0);
        chk("mid_diff_clr", 32'({diff, borrow, zero, neg, ovf}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        send_one(8'h64, 8'h0A, 8'h5A, "post_rst");

        // Randomized stream with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            case ($urandom_range(7))
                0:       begin a = 8'h80; b = 8'(($urandom_range(1) != 0) ? 8'h7F : 8'h01); end
                1:       begin a = 8'($urandom); b = a; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
